// File: rtl/nurse_station_responder.sv
// Nurse-station responder: captures bed calls, serves one bed at a time (bed 0 first), blinks LED/buzzer until ack, escalates if ignored.
// Latency: call press to pending = 3 clk edges (+DB_CYCLES with debounce); pending to ALERT = 1 edge; ack press to CLEAR = 3 edges.
// Backpressure: none; calls arriving while a bed is served stay pending until their turn. Optional NURSE_DEBOUNCE_EN adds input debouncers.
module nurse_station_responder #(
  parameter int BLINK_HALF = 25000000,
  parameter int ESC_CYCLES = 500000000,
  parameter int DB_CYCLES  = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] call,
  input  logic       ack,
  output logic [3:0] led,
  output logic [3:0] pending,
  output logic [1:0] serving_id,
  output logic       busy,
  output logic       buzzer,
  output logic       escalated
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF + 1) : 1;
  localparam int EW = (ESC_CYCLES > 1) ? $clog2(ESC_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [EW-1:0] ESC_MAX    = EW'(ESC_CYCLES);

  typedef enum logic [1:0] {IDLE, ALERT, CLEAR} state_t;

  state_t        state_q, state_n;
  logic [4:0]    sync1, sync2;   // bit 4 = ack, bits 3:0 = call
  logic [4:0]    cond;           // conditioned (synced or debounced) inputs
  logic [4:0]    cond_d;         // previous conditioned value for edge detect
  logic [4:0]    edges;
  logic [3:0]    call_edge;
  logic          ack_edge;
  logic [3:0]    pending_n;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [EW-1:0] esc_cnt;
  logic [3:0]    onehot;

  // Lowest-index set bit wins arbitration.
  function automatic logic [1:0] lowest_set(input logic [3:0] p);
    if (p[0])      return 2'd0;
    else if (p[1]) return 2'd1;
    else if (p[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {ack, call};
      sync2 <= sync1;
    end
  end

`ifdef NURSE_DEBOUNCE_EN
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  logic [DW-1:0] db_cnt [5];

  // Debounced value follows the synced input only after it has differed for DB_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == cond[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          cond[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign cond = sync2;
`endif

  // Registered copy of the conditioned inputs for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cond_d <= '0;
    else        cond_d <= cond;
  end

  assign edges     = cond & ~cond_d;
  assign call_edge = edges[3:0];
  assign ack_edge  = edges[4];
  assign onehot    = 4'b0001 << serving_id;

  // Pending flags: a new press edge wins over the clear of the bed just served.
  always_comb begin
    pending_n = pending;
    if (state_q == CLEAR) pending_n[serving_id] = 1'b0;
    pending_n = pending_n | call_edge;
  end

  // State, pending flags and served-bed latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pending    <= '0;
      serving_id <= '0;
    end else begin
      state_q <= state_n;
      pending <= pending_n;
      if (state_q == IDLE && pending != 4'b0000) serving_id <= lowest_set(pending);
    end
  end

  // Blink and escalation timers run only in ALERT; phase is armed to 1 on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
      esc_cnt   <= '0;
    end else if (state_q != ALERT) begin
      blink_cnt <= '0;
      phase     <= (state_n == ALERT);
      esc_cnt   <= '0;
    end else begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      if (esc_cnt != ESC_MAX) esc_cnt <= esc_cnt + 1'b1;
    end
  end

  // Next-state and indicator outputs.
  always_comb begin
    state_n   = state_q;
    busy      = 1'b0;
    led       = 4'b0000;
    buzzer    = 1'b0;
    escalated = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending != 4'b0000) state_n = ALERT;
      end
      ALERT: begin
        busy      = 1'b1;
        escalated = (esc_cnt == ESC_MAX);
        led       = escalated ? onehot : (onehot & {4{phase}});
        buzzer    = escalated | phase;
        if (ack_edge) state_n = CLEAR;
      end
      CLEAR: begin
        busy    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/nurse_station_responder.md
Name: nurse_station_responder

Overview:
- Nurse-station end of the bed call system: bed call buttons come in, the nurse acknowledge button comes in, and the block drives the station LEDs and buzzer.
- Captures bed presses as sticky pending requests and serves one bed at a time, bed 0 highest priority.
- Blinks the served bed's LED and pulses the buzzer until the nurse acknowledges; escalates to steady alarm if not acknowledged in time.
- Sits between the raw bed/nurse push-buttons and the station indicator outputs.

Parameters:
- BLINK_HALF, 25000000, clock cycles per blink half-period (LED on or off).
- ESC_CYCLES, 500000000, cycles in ALERT without acknowledge before escalation.
- DB_CYCLES, 1000000, debounce stable-time in cycles (used only with NURSE_DEBOUNCE_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- call  in  4  raw bed call buttons, level, asynchronous; bit i = bed i.
- ack  in  1  raw nurse acknowledge button, level, asynchronous.
- led  out  4  one-hot indicator of the served bed; blinks, or steady when escalated.
- pending  out  4  sticky pending-request flags, one per bed.
- serving_id  out  2  index of the served bed; valid while busy=1.
- busy  out  1  high in ALERT and CLEAR.
- buzzer  out  1  follows blink phase in ALERT; steady 1 once escalated.
- escalated  out  1  high when the current alert exceeded ESC_CYCLES.

Behaviour:
- Reset: all outputs, synchronizers, counters and pending = 0; FSM = IDLE.
- Input conditioning:
  - call[3:0] and ack each pass through a 2-flop synchronizer.
  - A registered copy of each synchronized value provides rising-edge detection.
- Pending capture:
  - A rising edge on synced call[i] sets pending[i].
  - A held level does not re-set pending[i] after it is cleared; the button must be released and pressed again.
  - Latency: pending[i] is visible after the 3rd rising clk edge following the call[i] assertion.
- FSM states:
  - IDLE:
    - busy=0, led=0, buzzer=0, escalated=0.
    - If pending != 0, go to ALERT next edge, latching serving_id = lowest-index set bit of pending.
  - ALERT:
    - busy=1.
    - Blink phase starts at 1 on entry and toggles every BLINK_HALF cycles.
    - led = onehot(serving_id) & {4{phase}}; buzzer = phase.
    - Escalation counter starts at 0 on entry and increments each cycle, saturating.
    - When the counter reaches ESC_CYCLES: escalated=1, led steady onehot(serving_id), buzzer steady 1.
    - Rising edge of synced ack: go to CLEAR.
    - Higher-priority requests arriving during ALERT do not preempt.
  - CLEAR (1 cycle):
    - Clears pending[serving_id]; led=0, buzzer=0, escalated=0; counters reset.
    - Next state is IDLE, which re-arbitrates on the following edge.
- Ack in IDLE or CLEAR: ignored, no effect.
- Simultaneous set and clear of the same pending bit (new press edge during CLEAR): set wins.
- Simultaneous calls: all captured; served in ascending index order, one per ack.
- Counter widths: $clog2(param+1); no wrap.
- Reset mid-operation: everything returns to reset values and pending requests are lost. A button still held when rst_n deasserts is seen as a rising edge and re-captured, because the synchronizer restarts at 0.

Optional Feature:
- NURSE_DEBOUNCE_EN defined:
  - Each synchronized input (4 call + ack) feeds its own debouncer.
  - The debounced value updates only after the synced input differs from it for DB_CYCLES consecutive cycles; any bounce resets that input's counter.
  - Edge detection uses the debounced values; latency grows by DB_CYCLES.
- Not defined: no debouncers; DB_CYCLES is unused; edge detection acts directly on the synchronized values.

Test Plan:
- Reset: hold rst_n=0 with call=4'b1111 -> all outputs 0; after release with call still held -> pending=4'b1111 after 3 edges, serving_id=0.
- Single call (BLINK_HALF=4, ESC_CYCLES=32): call[2] pulse -> pending=0100, next edge busy=1, serving_id=2, led alternates 0100/0000 every 4 cycles, buzzer matches; ack pulse -> one CLEAR cycle, pending=0000, busy=0.
- Priority: call=4'b1010 in the same cycle -> serving_id=1 first; after ack serving_id=3; after second ack pending=0, busy=0.
- Escalation: call[2], no ack for 32 cycles -> escalated=1, led steady 0100, buzzer steady 1; ack -> escalated=0, busy=0.
- No preemption / held button: bed 3 in ALERT, press bed 0 -> serving_id stays 3; ack -> serves 0; bed 3 held throughout -> pending[3] not re-set until release and re-press.
- Debounce (NURSE_DEBOUNCE_EN, DB_CYCLES=8): call[1] glitches of 3 cycles -> pending unchanged; call[1] held 8+ cycles -> pending[1]=1.
